// File: rtl/sync_fifo_pkg.sv
// Shared widths and helpers for the FIFO word serializer.
package sync_fifo_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int OUT_WIDTH  = 8;

  function automatic int ratio(input int data_w, input int out_w);
    return data_w / out_w;
  endfunction

  localparam int BEAT_CNT_W = $clog2(ratio(DATA_WIDTH, OUT_WIDTH));

  typedef logic [OUT_WIDTH-1:0] beat_t;

endpackage

// File: rtl/fifo_word_serializer.sv
// Drains a standard-mode FIFO and splits each word into a valid/ready beat stream.
// Define SERIALIZER_MSB_FIRST_EN to emit the most-significant slice first.
module fifo_word_serializer #(
  parameter int DATA_WIDTH = sync_fifo_pkg::DATA_WIDTH,
  parameter int OUT_WIDTH  = sync_fifo_pkg::OUT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_o,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  output logic [OUT_WIDTH-1:0]  out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  out_last_o
);

  import sync_fifo_pkg::*;

  localparam int RATIO = ratio(DATA_WIDTH, OUT_WIDTH);
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  if ((DATA_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_ratio
    $error("fifo_word_serializer: DATA_WIDTH must be a multiple (>=2x) of OUT_WIDTH");
  end

  logic [DATA_WIDTH-1:0] sr;
  logic [DATA_WIDTH-1:0] pf;
  logic                  sr_valid;
  logic                  pf_valid;
  logic                  rd_pend;
  logic                  started;
  logic [CNT_W-1:0]      beat_cnt;

  logic xfer;
  logic last_beat;
  logic sr_done;
  logic sr_free;

  assign xfer      = sr_valid && out_ready_i;
  assign last_beat = (beat_cnt == CNT_W'(RATIO - 1));
  assign sr_done   = xfer && last_beat;
  assign sr_free   = !sr_valid || sr_done;

  // Only held words count toward occupancy; rd_pend blocks back-to-back reads
  // so an in-flight word always has a free slot waiting for it.
  assign fifo_rd_o = started && !fifo_empty_i && !rd_pend &&
                     (({1'b0, sr_valid} + {1'b0, pf_valid}) < 2'd2);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sr       <= '0;
      pf       <= '0;
      sr_valid <= 1'b0;
      pf_valid <= 1'b0;
      rd_pend  <= 1'b0;
      started  <= 1'b0;
      beat_cnt <= '0;
    end else begin
      started <= 1'b1;
      rd_pend <= fifo_rd_o;

      if (sr_done) begin
        beat_cnt <= '0;
        if (pf_valid) begin
          sr       <= pf;
          pf_valid <= 1'b0;
        end else if (!rd_pend) begin
          sr_valid <= 1'b0;
        end
      end else if (xfer) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end

      // Returning read data goes straight to SR when it is (about to be) free.
      if (rd_pend) begin
        if (sr_free && !pf_valid) begin
          sr       <= fifo_rd_data_i;
          sr_valid <= 1'b1;
          beat_cnt <= '0;
        end else begin
          pf       <= fifo_rd_data_i;
          pf_valid <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    out_data_o = '0;
`ifdef SERIALIZER_MSB_FIRST_EN
    out_data_o = sr[(RATIO - 1 - int'(beat_cnt)) * OUT_WIDTH +: OUT_WIDTH];
`else
    out_data_o = sr[int'(beat_cnt) * OUT_WIDTH +: OUT_WIDTH];
`endif
  end

  assign out_valid_o = sr_valid;
  assign out_last_o  = sr_valid && last_beat;

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Scoreboard bench for fifo_word_serializer with a behavioural standard-mode FIFO.
module tb_fifo_word_serializer;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        fifo_empty_i;
  logic        fifo_rd_o;
  logic [31:0] fifo_rd_data_i = '0;
  logic [7:0]  out_data_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        out_last_o;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_count = 0;
  int rd_empty_err = 0;

  fifo_word_serializer #(.DATA_WIDTH(32), .OUT_WIDTH(8)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .fifo_empty_i   (fifo_empty_i),
    .fifo_rd_o      (fifo_rd_o),
    .fifo_rd_data_i (fifo_rd_data_i),
    .out_data_o     (out_data_o),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_last_o     (out_last_o)
  );

  always #5 clk_i = ~clk_i;

  assign fifo_empty_i = (wr_ptr == rd_ptr);

  // Standard-mode FIFO: data appears the cycle after the read strobe.
  always @(posedge clk_i) begin
    if (fifo_rd_o) begin
      if (wr_ptr == rd_ptr) rd_empty_err <= rd_empty_err + 1;
      fifo_rd_data_i <= mem[rd_ptr % 16];
      rd_ptr         <= rd_ptr + 1;
      rd_count       <= rd_count + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] beat_of(input logic [31:0] w, input int i);
    logic [31:0] tmp;
    tmp = w;
`ifdef SERIALIZER_MSB_FIRST_EN
    return tmp[(3 - i) * 8 +: 8];
`else
    return tmp[i * 8 +: 8];
`endif
  endfunction

  task automatic push_word(input logic [31:0] w);
    exp_t e;
    mem[wr_ptr % 16] = w;
    wr_ptr = wr_ptr + 1;
    for (int i = 0; i < 4; i++) begin
      e.data = beat_of(w, i);
      e.last = (i == 3);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk_i);
      n++;
    end
    check(name, exp_q.size(), 0);
    @(posedge clk_i); #1;
  endtask

  // Monitor: pop expectations on each accepted beat and check hold stability.
  logic       hold_pend = 1'b0;
  logic [7:0] held_data;
  logic       held_last;
  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_n_i) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", 32'(out_valid_o), 32'd1);
        check("hold_data",  32'(out_data_o),  32'(held_data));
        check("hold_last",  32'(out_last_o),  32'(held_last));
      end
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 32'(out_data_o), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", 32'(out_data_o), 32'(e.data));
          check("beat_last", 32'(out_last_o), 32'(e.last));
        end
      end
      hold_pend = out_valid_o && !out_ready_i;
      held_data = out_data_o;
      held_last = out_last_o;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rd0;
    int n;
    int bubbles;
    int valid_seen;
    logic [31:0] w;
    logic ready_pat [7];

    rst_n_i     = 1'b0;
    out_ready_i = 1'b1;
    #2;
    check("rst_rd",    32'(fifo_rd_o),   32'd0);
    check("rst_valid", 32'(out_valid_o), 32'd0);
    check("rst_last",  32'(out_last_o),  32'd0);
    check("rst_data",  32'(out_data_o),  32'd0);
    repeat (3) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;

    // Single word, ready held high; exactly one read.
    rd0 = rd_count;
    push_word(32'h4433_2211);
    wait_drain("drain_single", 40);
    check("single_rd_pulses", rd_count - rd0, 32'd1);

    // Three preloaded words must stream as 12 contiguous beats.
    push_word(32'hA3A2_A1A0);
    push_word(32'hB3B2_B1B0);
    push_word(32'hC3C2_C1C0);
    n = 0;
    @(negedge clk_i);
    while (!out_valid_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    bubbles = out_valid_o ? 0 : 1;
    for (int i = 1; i < 12; i++) begin
      @(negedge clk_i);
      if (!out_valid_o) bubbles++;
    end
    check("no_bubble", bubbles, 32'd0);
    wait_drain("drain_three", 40);

    // Backpressure pattern; the monitor checks each held beat.
    ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    out_ready_i = 1'b0;
    push_word(32'hDDCC_BBAA);
    repeat (4) @(posedge clk_i);
    for (int i = 0; i < 7; i++) begin
      #1 out_ready_i = ready_pat[i];
      @(posedge clk_i);
    end
    #1;
    check("bp_drained", exp_q.size(), 32'd0);
    out_ready_i = 1'b1;
    wait_drain("drain_bp", 20);

    // Reset mid-word after beat 0x22 of 0x44332211 has transferred.
    push_word(32'h4433_2211);
    n = 0;
    while (exp_q.size() != 2 && n < 40) begin
      @(posedge clk_i);
      n++;
    end
    #1 rst_n_i = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid_o), 32'd0);
    check("mid_rst_last",  32'(out_last_o),  32'd0);
    check("mid_rst_data",  32'(out_data_o),  32'd0);
    check("mid_rst_rd",    32'(fifo_rd_o),   32'd0);
    check("mid_rst_left",  exp_q.size(),     32'd2);
    exp_q.delete();
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    valid_seen = 0;
    repeat (8) begin
      @(negedge clk_i);
      if (out_valid_o) valid_seen++;
    end
    check("post_rst_idle", valid_seen, 32'd0);

    // Refill after an idle stretch: read same cycle, beat 0 two cycles later.
    repeat (2) @(posedge clk_i);
    #1;
    w = 32'h0F0E_0D0C;
    push_word(w);
    @(negedge clk_i);
    check("lat_rd_c0",    32'(fifo_rd_o),   32'd1);
    check("lat_valid_c0", 32'(out_valid_o), 32'd0);
    @(negedge clk_i);
    check("lat_valid_c1", 32'(out_valid_o), 32'd0);
    @(negedge clk_i);
    check("lat_valid_c2", 32'(out_valid_o), 32'd1);
    check("lat_data_c2",  32'(out_data_o),  32'(beat_of(w, 0)));
    wait_drain("drain_lat", 20);

    check("rd_while_empty", rd_empty_err, 32'd0);
    check("sb_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
